// File: rtl/bcd_scan_display.sv
// Time-multiplexed 4-digit 7-segment driver for the BCD stopwatch bus, with per-slot anti-ghosting dead time.
// Optional macro LEADING_ZERO_BLANK_EN suppresses leading zero digits in slots 3..1.
module bcd_scan_display #(
   parameter int unsigned SCAN_DIV    = 50000,
   parameter int unsigned BLANK_CYC   = 500,
   parameter bit          DIG_ACT_LOW = 1'b1,
   parameter bit          SEG_ACT_LOW = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] bcd_num,
   input  logic [3:0]  dp_mask,
   output logic [3:0]  dig,
   output logic [6:0]  seg,
   output logic        dp,
   output logic        frame_tick
);

   localparam int unsigned   PW        = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [PW-1:0] LAST_C    = PW'(SCAN_DIV - 1);
   localparam logic [PW-1:0] BLANK_C   = PW'(BLANK_CYC);
   localparam logic [PW-1:0] ONE_C     = PW'(1);
   localparam logic [3:0]    DIG_OFF_C = {4{DIG_ACT_LOW}};
   localparam logic [6:0]    SEG_OFF_C = {7{SEG_ACT_LOW}};

   function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'h3F;
         4'd1:    s = 7'h06;
         4'd2:    s = 7'h5B;
         4'd3:    s = 7'h4F;
         4'd4:    s = 7'h66;
         4'd5:    s = 7'h6D;
         4'd6:    s = 7'h7D;
         4'd7:    s = 7'h07;
         4'd8:    s = 7'h7F;
         4'd9:    s = 7'h6F;
         default: s = 7'h40;
      endcase
      return s;
   endfunction

   logic [PW-1:0] prescaler_r;
   logic [1:0]    slot_r;
   logic [15:0]   sync1_r;
   logic [15:0]   sync2_r;
   logic [15:0]   shadow_r;
   logic [3:0]    dig_r;
   logic [6:0]    seg_r;
   logic          dp_r;
   logic          frame_tick_r;

   logic          slot_wrap_s;
   logic          frame_wrap_s;
   logic [3:0]    digit_s;
   logic          blank_lz_s;
   logic          show_s;
   logic [3:0]    dig_hi_s;
   logic [6:0]    seg_hi_s;
   logic          dp_hi_s;

   // Scan timing decode and next-output computation (before polarity XOR)
   always_comb begin
      slot_wrap_s  = (prescaler_r == LAST_C);
      frame_wrap_s = slot_wrap_s && (slot_r == 2'd3);
      digit_s      = shadow_r[{slot_r, 2'b00} +: 4];
`ifdef LEADING_ZERO_BLANK_EN
      case (slot_r)
         2'd3:    blank_lz_s = (shadow_r[15:12] == 4'h0);
         2'd2:    blank_lz_s = (shadow_r[15:8] == 8'h00);
         2'd1:    blank_lz_s = (shadow_r[15:4] == 12'h000);
         default: blank_lz_s = 1'b0;
      endcase
`else
      blank_lz_s   = 1'b0;
`endif
      show_s       = (prescaler_r >= BLANK_C) && !blank_lz_s;
      if (show_s) begin
         dig_hi_s = 4'b0001 << slot_r;
         seg_hi_s = bcd_to_seg(digit_s);
         dp_hi_s  = dp_mask[slot_r];
      end else begin
         dig_hi_s = 4'b0000;
         seg_hi_s = 7'h00;
         dp_hi_s  = 1'b0;
      end
   end

   // Prescaler, slot counter, input resynchroniser, frame shadow and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prescaler_r  <= '0;
         slot_r       <= 2'd0;
         sync1_r      <= 16'h0000;
         sync2_r      <= 16'h0000;
         shadow_r     <= 16'h0000;
         dig_r        <= DIG_OFF_C;
         seg_r        <= SEG_OFF_C;
         dp_r         <= SEG_ACT_LOW;
         frame_tick_r <= 1'b0;
      end else begin
         if (slot_wrap_s) begin
            prescaler_r <= '0;
            slot_r      <= slot_r + 2'd1;
         end else begin
            prescaler_r <= prescaler_r + ONE_C;
         end
         sync1_r <= bcd_num;
         sync2_r <= sync1_r;
         // Only take a frame value that was stable over both sync stages, so a mid-carry change is never shown torn
         if (frame_wrap_s && (sync1_r == sync2_r)) begin
            shadow_r <= sync2_r;
         end
         dig_r        <= dig_hi_s ^ DIG_OFF_C;
         seg_r        <= seg_hi_s ^ SEG_OFF_C;
         dp_r         <= dp_hi_s ^ SEG_ACT_LOW;
         frame_tick_r <= frame_wrap_s;
      end
   end

   assign dig        = dig_r;
   assign seg        = seg_r;
   assign dp         = dp_r;
   assign frame_tick = frame_tick_r;

endmodule

// File: tb/tb_bcd_scan_display.sv
// Randomised self-checking bench for bcd_scan_display; the reference model derives every output from the
// number of clock edges since reset release and the history of sampled bcd_num values.
module tb_bcd_scan_display;

   localparam int SCAN_DIV  = 8;
   localparam int BLANK_CYC = 2;
   localparam logic [6:0] SEG_TAB [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                           7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] bcd_num = 16'h0000;
   logic [3:0]  dp_mask = 4'h0;
   logic [3:0]  dig;
   logic [6:0]  seg;
   logic        dp;
   logic        frame_tick;

   int          n_checks = 0;
   int          n_fail   = 0;
   int          k        = 0;
   logic [15:0] hist [0:4095];
   logic [15:0] shadow_m = 16'h0000;

   always #5 clk = ~clk;

   bcd_scan_display #(
      .SCAN_DIV    (SCAN_DIV),
      .BLANK_CYC   (BLANK_CYC),
      .DIG_ACT_LOW (1'b1),
      .SEG_ACT_LOW (1'b1)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .bcd_num    (bcd_num),
      .dp_mask    (dp_mask),
      .dig        (dig),
      .seg        (seg),
      .dp         (dp),
      .frame_tick (frame_tick)
   );

   task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (edge %0d)", tag, obs, exp, k);
      end
   endtask

   function automatic logic [6:0] seg_ref(input logic [3:0] d);
      if (d > 4'd9) return 7'h40;
      return SEG_TAB[d];
   endfunction

   function automatic logic [15:0] hist_at(input int idx);
      if (idx < 1) return 16'h0000;
      return hist[idx];
   endfunction

   // One clock edge: sample inputs, predict outputs from edge count, compare
   task automatic step();
      int          pre;
      int          slot;
      logic        blank;
      logic        ft_e;
      logic [3:0]  one_hot;
      logic [3:0]  dig_e;
      logic [6:0]  seg_e;
      logic        dp_e;
      @(posedge clk);
      k++;
      hist[k] = bcd_num;
      pre   = (k - 1) % SCAN_DIV;
      slot  = ((k - 1) / SCAN_DIV) % 4;
      blank = (pre < BLANK_CYC);
`ifdef LEADING_ZERO_BLANK_EN
      if (slot > 0 && (shadow_m >> (4 * slot)) == 16'h0000) blank = 1'b1;
`endif
      if (blank) begin
         dig_e = 4'hF;
         seg_e = 7'h7F;
         dp_e  = 1'b1;
      end else begin
         one_hot = 4'b0001 << slot;
         dig_e   = ~one_hot;
         seg_e   = ~seg_ref(shadow_m[4*slot +: 4]);
         dp_e    = ~dp_mask[slot];
      end
      ft_e = (pre == SCAN_DIV - 1) && (slot == 3);
      if (ft_e && hist_at(k - 1) == hist_at(k - 2)) shadow_m = hist_at(k - 1);
      #1;
      check_val("dig", {12'h000, dig}, {12'h000, dig_e});
      check_val("seg", {9'h000, seg}, {9'h000, seg_e});
      check_val("dp", {15'h0000, dp}, {15'h0000, dp_e});
      check_val("frame_tick", {15'h0000, frame_tick}, {15'h0000, ft_e});
      check_val("onehot", {15'h0000, ($countones(~dig) <= 1)}, 16'h0001);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   // Assert reset away from any edge, check outputs go OFF at once, release on a falling edge
   task automatic apply_reset();
      #3 rst = 1'b1;
      #2;
      check_val("rst_dig", {12'h000, dig}, 16'h000F);
      check_val("rst_seg", {9'h000, seg}, 16'h007F);
      check_val("rst_dp", {15'h0000, dp}, 16'h0001);
      check_val("rst_ft", {15'h0000, frame_tick}, 16'h0000);
      repeat (3) @(posedge clk);
      #1;
      check_val("rst_hold_dig", {12'h000, dig}, 16'h000F);
      check_val("rst_hold_seg", {9'h000, seg}, 16'h007F);
      @(negedge clk);
      rst      = 1'b0;
      k        = 0;
      shadow_m = 16'h0000;
   endtask

   initial begin
      int n;
      logic [15:0] r;
      repeat (2) @(posedge clk);
      apply_reset();

      // Reset-state frame, then first frame_tick and slot 0 ON window
      run(40);

      bcd_num = 16'h5931;
      run(64);

      // Value changes one edge before the frame wrap: old value must persist a frame
      bcd_num = 16'h0959;
      run(34);
      n = 0;
      while ((k % 32) != 30 && n < 40) begin
         step();
         n++;
      end
      bcd_num = 16'h1000;
      run(70);

      bcd_num = 16'h00A0;
      dp_mask = 4'b0100;
      run(64);

      dp_mask = 4'h0;
      bcd_num = 16'h0007;
      run(64);
      bcd_num = 16'h0000;
      run(64);

      // Random traffic: mostly valid BCD, sometimes arbitrary codes, frequent tearing opportunities
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(15, 0) == 0) begin
            r = 16'($urandom);
            if ($urandom_range(3, 0) != 0) begin
               for (int j = 0; j < 4; j++) r[4*j +: 4] = 4'($urandom_range(9, 0));
            end
            bcd_num = r;
         end
         if ($urandom_range(63, 0) == 0) dp_mask = 4'($urandom);
         step();
      end

      // Reset in the middle of slot 2's ON window
      bcd_num = 16'h5931;
      dp_mask = 4'hF;
      n = 0;
      while (!(((k - 1) % SCAN_DIV) == 4 && (((k - 1) / SCAN_DIV) % 4) == 2) && n < 64) begin
         step();
         n++;
      end
      check_val("slot2_on_before_rst", {12'h000, dig}, 16'h000B);
      apply_reset();
      run(40);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
